// File: rtl/io_port_responder.sv
// Peripheral side of the DSP IN/OUT port bus: port decode, scratch registers,
// and two valid/ready FIFOs bridging DSP port accesses to an external host.
module io_port_responder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       io_addr,
    input  logic             io_wr,
    input  logic [WIDTH-1:0] io_wdata,
    input  logic             io_rd,
    output logic [WIDTH-1:0] io_rdata,
    output logic             io_bio_n,
    output logic             int_n,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] tx_mem_q [DEPTH];
    logic [WIDTH-1:0] tx_mem_d [DEPTH];
    logic [WIDTH-1:0] rx_mem_q [DEPTH];
    logic [WIDTH-1:0] rx_mem_d [DEPTH];
    logic [WIDTH-1:0] scratch_q [5];
    logic [WIDTH-1:0] scratch_d [5];
    logic [PW-1:0]    tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PW-1:0]    rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0]    tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic             tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
    logic             irq_en_q, irq_en_d;
    logic [WIDTH-1:0] io_rdata_q, io_rdata_d;

    logic             wr_s, ctrl_wr_s, flush_s, clr_s;
    logic             tx_push_req_s, tx_push_s, tx_pop_s;
    logic             rx_pop_req_s, rx_pop_s, rx_push_s;
    logic [15:0]      status_s;

    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic push,
                                                 input logic pop);
        case ({push, pop})
            2'b10:   return cnt + CNT_ONE;
            2'b01:   return cnt - CNT_ONE;
            default: return cnt;
        endcase
    endfunction

    // A read strobe wins over a simultaneous write, so writes are qualified by !io_rd.
    assign wr_s          = io_wr & ~io_rd;
    assign ctrl_wr_s     = wr_s & (io_addr == 3'd2);
    assign flush_s       = ctrl_wr_s & io_wdata[0];
    assign clr_s         = ctrl_wr_s & io_wdata[2];

    // A full TX FIFO still accepts a push when the host drains the head on the same edge.
    assign tx_pop_s      = (tx_count_q != CNT_ZERO) & tx_ready & ~flush_s;
    assign tx_push_req_s = wr_s & (io_addr == 3'd0);
    assign tx_push_s     = tx_push_req_s & ((tx_count_q != CNT_FULL) | tx_pop_s);
    assign rx_push_s     = rx_valid & (rx_count_q != CNT_FULL) & ~flush_s;
    assign rx_pop_req_s  = io_rd & (io_addr == 3'd0);
    assign rx_pop_s      = rx_pop_req_s & (rx_count_q != CNT_ZERO);

    assign status_s = {4'(tx_count_q), 4'(rx_count_q), 3'b000, irq_en_q, tx_ovf_q,
                       rx_unf_q, (tx_count_q == CNT_FULL), (rx_count_q != CNT_ZERO)};

    // Next-state for FIFOs, flags, control and scratch registers.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tx_mem_d[i] = (tx_push_s && (tx_wptr_q == PW'(i))) ? io_wdata : tx_mem_q[i];
            rx_mem_d[i] = (rx_push_s && (rx_wptr_q == PW'(i))) ? rx_data : rx_mem_q[i];
        end
        for (int i = 0; i < 5; i++) begin
            scratch_d[i] = (wr_s && (io_addr == 3'(i + 3))) ? io_wdata : scratch_q[i];
        end
        tx_wptr_d  = flush_s ? PTR_ZERO : (tx_push_s ? tx_wptr_q + PTR_ONE : tx_wptr_q);
        tx_rptr_d  = flush_s ? PTR_ZERO : (tx_pop_s ? tx_rptr_q + PTR_ONE : tx_rptr_q);
        rx_wptr_d  = flush_s ? PTR_ZERO : (rx_push_s ? rx_wptr_q + PTR_ONE : rx_wptr_q);
        rx_rptr_d  = flush_s ? PTR_ZERO : (rx_pop_s ? rx_rptr_q + PTR_ONE : rx_rptr_q);
        tx_count_d = flush_s ? CNT_ZERO : next_count(tx_count_q, tx_push_s, tx_pop_s);
        rx_count_d = flush_s ? CNT_ZERO : next_count(rx_count_q, rx_push_s, rx_pop_s);
        tx_ovf_d   = clr_s ? 1'b0 : (tx_ovf_q | (tx_push_req_s & ~tx_push_s));
        rx_unf_d   = clr_s ? 1'b0 : (rx_unf_q | (rx_pop_req_s & ~rx_pop_s));
        irq_en_d   = ctrl_wr_s ? io_wdata[1] : irq_en_q;
    end

    // Read data mux; io_rdata holds its value between IN strobes.
    always_comb begin
        io_rdata_d = io_rdata_q;
        if (io_rd) begin
            case (io_addr)
                3'd0:    io_rdata_d = rx_pop_s ? rx_mem_q[rx_rptr_q] : {WIDTH{1'b0}};
                3'd1:    io_rdata_d = WIDTH'(status_s);
                3'd2:    io_rdata_d = WIDTH'({irq_en_q, 1'b0});
                default: io_rdata_d = scratch_q[io_addr - 3'd3];
            endcase
        end else begin
            io_rdata_d = io_rdata_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem_q[i] <= {WIDTH{1'b0}};
                rx_mem_q[i] <= {WIDTH{1'b0}};
            end
            for (int i = 0; i < 5; i++) begin
                scratch_q[i] <= {WIDTH{1'b0}};
            end
            tx_wptr_q  <= PTR_ZERO;
            tx_rptr_q  <= PTR_ZERO;
            rx_wptr_q  <= PTR_ZERO;
            rx_rptr_q  <= PTR_ZERO;
            tx_count_q <= CNT_ZERO;
            rx_count_q <= CNT_ZERO;
            tx_ovf_q   <= 1'b0;
            rx_unf_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            io_rdata_q <= {WIDTH{1'b0}};
        end else begin
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            scratch_q  <= scratch_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_unf_q   <= rx_unf_d;
            irq_en_q   <= irq_en_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    assign io_rdata = io_rdata_q;
    assign tx_valid = (tx_count_q != CNT_ZERO);
    assign tx_data  = tx_mem_q[tx_rptr_q];
    assign rx_ready = (rx_count_q != CNT_FULL);
    assign io_bio_n = ~(rx_count_q != CNT_ZERO);
    assign int_n    = ~(irq_en_q & (rx_count_q != CNT_ZERO));

endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: expected IN data and TX words are
// queued by the stimulus and compared by a monitor when the DUT presents them.
module tb_io_port_responder;

    logic        clk;
    logic        reset_n;
    logic [2:0]  io_addr;
    logic        io_wr;
    logic [15:0] io_wdata;
    logic        io_rd;
    logic [15:0] io_rdata;
    logic        io_bio_n;
    logic        int_n;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] rd_exp_q[$];
    logic [15:0] tx_exp_q[$];

    io_port_responder #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .io_addr(io_addr), .io_wr(io_wr),
        .io_wdata(io_wdata), .io_rd(io_rd), .io_rdata(io_rdata),
        .io_bio_n(io_bio_n), .int_n(int_n), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares TX handshakes and IN results against the queued expectations.
    initial begin
        logic rd_seen;
        logic tx_seen;
        logic [15:0] tx_word;
        forever begin
            @(posedge clk);
            rd_seen = io_rd & reset_n;
            tx_seen = tx_valid & tx_ready & reset_n;
            tx_word = tx_data;
            if (tx_seen) begin
                if (tx_exp_q.size() == 0) check("tx_unexpected", tx_word, 16'hxxxx);
                else check("tx_data", tx_word, tx_exp_q.pop_front());
            end
            #1;
            if (rd_seen) begin
                if (rd_exp_q.size() == 0) check("rd_unexpected", io_rdata, 16'hxxxx);
                else check("io_rdata", io_rdata, rd_exp_q.pop_front());
            end
        end
    end

    task automatic port_out(input logic [2:0] a, input logic [15:0] d);
        io_addr = a; io_wdata = d; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic port_in(input logic [2:0] a, input logic [15:0] exp);
        io_addr = a; io_rd = 1'b1;
        rd_exp_q.push_back(exp);
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    task automatic host_push(input logic [15:0] w);
        logic done;
        done = 1'b0;
        rx_valid = 1'b1; rx_data = w;
        for (int c = 0; c < 20 && !done; c++) begin
            if (rx_ready) done = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!done) check("host_push_timeout", 16'h0000, 16'h0001);
    endtask

    initial begin
        reset_n = 1'b0; io_addr = 3'd0; io_wr = 1'b0; io_wdata = 16'h0000; io_rd = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_io_rdata", io_rdata, 16'h0000);
        check("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
        check("rst_rx_ready", {15'd0, rx_ready}, 16'h0001);
        check("rst_io_bio_n", {15'd0, io_bio_n}, 16'h0001);
        check("rst_int_n", {15'd0, int_n}, 16'h0001);
        reset_n = 1'b1;
        @(negedge clk);

        // TX ordering to the host.
        port_out(3'd0, 16'h1234); tx_exp_q.push_back(16'h1234);
        port_out(3'd0, 16'hABCD); tx_exp_q.push_back(16'hABCD);
        check("tx_valid_filled", {15'd0, tx_valid}, 16'h0001);
        port_in(3'd1, 16'h2000);
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        tx_ready = 1'b0;
        check("tx_valid_drained", {15'd0, tx_valid}, 16'h0000);

        // RX fill to DEPTH, fifth word stalls until an IN frees a slot.
        for (int i = 1; i <= 4; i++) host_push(16'(i));
        check("rx_ready_full", {15'd0, rx_ready}, 16'h0000);
        check("bio_n_nonempty", {15'd0, io_bio_n}, 16'h0000);
        port_in(3'd1, 16'h0401);
        rx_valid = 1'b1; rx_data = 16'h0005;
        repeat (2) @(negedge clk);
        check("rx_stalled", {15'd0, rx_ready}, 16'h0000);
        io_addr = 3'd0; io_rd = 1'b1; rd_exp_q.push_back(16'h0001);
        @(negedge clk);
        io_rd = 1'b0;
        check("rx_ready_after_pop", {15'd0, rx_ready}, 16'h0001);
        @(negedge clk);
        rx_valid = 1'b0;
        check("rx_fifth_accepted", {15'd0, rx_ready}, 16'h0000);
        for (int i = 2; i <= 5; i++) port_in(3'd0, 16'(i));
        check("bio_n_empty", {15'd0, io_bio_n}, 16'h0001);

        // RX underflow and sticky clear.
        port_in(3'd0, 16'h0000);
        port_in(3'd1, 16'h0004);
        port_out(3'd2, 16'h0004);
        port_in(3'd1, 16'h0000);

        // TX overflow, then full push accepted alongside a host pop.
        port_out(3'd0, 16'h1111); tx_exp_q.push_back(16'h1111);
        port_out(3'd0, 16'h2222); tx_exp_q.push_back(16'h2222);
        port_out(3'd0, 16'h3333); tx_exp_q.push_back(16'h3333);
        port_out(3'd0, 16'h4444); tx_exp_q.push_back(16'h4444);
        port_out(3'd0, 16'h9999);
        port_in(3'd1, 16'h400A);
        io_addr = 3'd0; io_wdata = 16'h9999; io_wr = 1'b1; tx_ready = 1'b1;
        tx_exp_q.push_back(16'h9999);
        @(negedge clk);
        io_wr = 1'b0; tx_ready = 1'b0;
        port_in(3'd1, 16'h400A);
        tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        tx_ready = 1'b0;
        check("tx_valid_after_drain", {15'd0, tx_valid}, 16'h0000);
        port_out(3'd2, 16'h0004);

        // Interrupt enable and BIO.
        port_out(3'd2, 16'h0002);
        rx_valid = 1'b1; rx_data = 16'h00AA;
        @(negedge clk);
        rx_valid = 1'b0;
        check("int_n_low", {15'd0, int_n}, 16'h0000);
        check("bio_n_low", {15'd0, io_bio_n}, 16'h0000);
        port_in(3'd2, 16'h0002);
        port_in(3'd0, 16'h00AA);
        check("int_n_high", {15'd0, int_n}, 16'h0001);
        check("bio_n_high", {15'd0, io_bio_n}, 16'h0001);

        // Flush discards both FIFOs and a host push on the same edge.
        host_push(16'h00B1);
        host_push(16'h00B2);
        port_out(3'd0, 16'h7777);
        rx_valid = 1'b1; rx_data = 16'hDEAD;
        port_out(3'd2, 16'h0003);
        rx_valid = 1'b0;
        port_in(3'd1, 16'h0010);
        check("flush_tx_valid", {15'd0, tx_valid}, 16'h0000);
        check("flush_int_n", {15'd0, int_n}, 16'h0001);
        port_out(3'd2, 16'h0000);

        // Scratch registers and strobe conflict.
        port_out(3'd5, 16'hBEEF);
        port_in(3'd5, 16'hBEEF);
        io_addr = 3'd5; io_wdata = 16'h0000; io_wr = 1'b1; io_rd = 1'b1;
        rd_exp_q.push_back(16'hBEEF);
        @(negedge clk);
        io_wr = 1'b0; io_rd = 1'b0;
        port_in(3'd5, 16'hBEEF);
        port_out(3'd3, 16'h1357);
        port_out(3'd7, 16'h2468);
        port_in(3'd3, 16'h1357);
        port_in(3'd7, 16'h2468);

        // Reset mid-sequence clears scratch and pending TX data.
        port_out(3'd0, 16'h5555);
        port_out(3'd6, 16'h6666);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tx_exp_q.delete();
        check("reset_tx_valid", {15'd0, tx_valid}, 16'h0000);
        check("reset_io_rdata", io_rdata, 16'h0000);
        port_in(3'd5, 16'h0000);
        port_in(3'd6, 16'h0000);

        repeat (2) @(negedge clk);
        check("rd_queue_empty", 16'(rd_exp_q.size()), 16'h0000);
        check("tx_queue_empty", 16'(tx_exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
